// File: rtl/mips_width_pkg.sv
// rtl/mips_width_pkg.sv - shared widths and serializer state encoding
// Purpose: width constants and FSM state type shared by the serializer and its checker.
// Ports: none (package).
package mips_width_pkg;

    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND_LO = 2'd1,
        ST_SEND_HI = 2'd2
    } state_t;

endpackage

// File: rtl/narrow32t16_serializer_if.sv
// rtl/narrow32t16_serializer_if.sv - word-in / halfword-out stream interface
// Purpose: groups the input word handshake and the output halfword handshake.
// Ports (signals):
//   in_valid/in_ready/in_data/in_sign/in_narrow    word stream into the serializer
//   out_valid/out_ready/out_data/out_last/out_ovf  halfword stream out of the serializer
// Modports: slave = serializer side, master = producer/consumer side.
interface narrow32t16_serializer_if
    import mips_width_pkg::*;
#(
    parameter int IN_W  = WORD_W,
    parameter int OUT_W = HALF_W
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_sign;
    logic             in_narrow;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_last;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_data, in_sign, in_narrow, out_ready,
        output in_ready, out_valid, out_data, out_last, out_ovf
    );

    modport master (
        output in_valid, in_data, in_sign, in_narrow, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_ovf
    );
endinterface

// File: rtl/narrow32t16_serializer_ext_check.sv
// rtl/narrow32t16_serializer_ext_check.sv - lossless sign/zero extension check
// Purpose: reports whether hi is exactly the sign (sign=1) or zero (sign=0) extension of lo.
// Ports:
//   hi_i        upper half of the word
//   lo_i        lower half of the word
//   sign_i      1 = sign extension, 0 = zero extension
//   lossless_o  1 when narrowing to lo loses no information
module ext_check
    import mips_width_pkg::*;
#(
    parameter int W = HALF_W
) (
    input  logic [W-1:0] hi_i,
    input  logic [W-1:0] lo_i,
    input  logic         sign_i,
    output logic         lossless_o
);
    always_comb begin
        if (sign_i) begin
            lossless_o = (hi_i == {W{lo_i[W-1]}});
        end else begin
            lossless_o = (hi_i == '0);
        end
    end
endmodule

// File: rtl/narrow32t16_serializer.sv
// rtl/narrow32t16_serializer.sv - 32-bit word to 16-bit halfword stream serializer
// Purpose: emits each accepted word as one halfword (narrow, with overflow flag) or two
//   halfwords low-first (full). Optional overflow counter under macro NARROW_OVF_CNT_EN.
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   bus          stream interface (slave modport)
//   ovf_cnt_clr  synchronous counter clear     (NARROW_OVF_CNT_EN only)
//   ovf_cnt      saturating overflow beat count (NARROW_OVF_CNT_EN only)
module narrow32t16_serializer
    import mips_width_pkg::*;
#(
    parameter int IN_W  = WORD_W,
    parameter int OUT_W = HALF_W
`ifdef NARROW_OVF_CNT_EN
    ,
    parameter int CNT_W = 8
`endif
) (
    input  logic                      clk,
    input  logic                      rst_n,
    narrow32t16_serializer_if.slave   bus
`ifdef NARROW_OVF_CNT_EN
    ,
    input  logic                      ovf_cnt_clr,
    output logic [CNT_W-1:0]          ovf_cnt
`endif
);
    state_t           state_q, state_d;
    logic [IN_W-1:0]  data_q;
    logic             sign_q;
    logic             narrow_q;

    logic [OUT_W-1:0] lo, hi;
    logic             lossless;
    logic             accept;
    logic             out_valid_c;
    logic [OUT_W-1:0] out_data_c;
    logic             out_last_c;
    logic             out_ovf_c;
    logic             in_ready_c;

    assign lo = data_q[OUT_W-1:0];
    assign hi = data_q[IN_W-1:OUT_W];

    ext_check #(.W(OUT_W)) u_ext_check (
        .hi_i       (hi),
        .lo_i       (lo),
        .sign_i     (sign_q),
        .lossless_o (lossless)
    );

    // Outputs are decoded from the state and the capture register, so they stay
    // stable for as long as the state is held by backpressure.
    always_comb begin
        state_d     = state_q;
        out_valid_c = 1'b0;
        out_data_c  = '0;
        out_last_c  = 1'b0;
        out_ovf_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d = ST_SEND_LO;
                end
            end
            ST_SEND_LO: begin
                out_valid_c = 1'b1;
                out_data_c  = lo;
                out_last_c  = narrow_q;
                out_ovf_c   = narrow_q & ~lossless;
                if (bus.out_ready) begin
                    if (!narrow_q) begin
                        state_d = ST_SEND_HI;
                    end else begin
                        state_d = bus.in_valid ? ST_SEND_LO : ST_IDLE;
                    end
                end
            end
            ST_SEND_HI: begin
                out_valid_c = 1'b1;
                out_data_c  = hi;
                out_last_c  = 1'b1;
                if (bus.out_ready) begin
                    state_d = bus.in_valid ? ST_SEND_LO : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A new word may enter in the same cycle the last beat of the current one leaves.
    assign in_ready_c = (state_q == ST_IDLE) | (out_valid_c & bus.out_ready & out_last_c);
    assign accept     = bus.in_valid & in_ready_c;

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_data_c;
    assign bus.out_last  = out_last_c;
    assign bus.out_ovf   = out_ovf_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            sign_q   <= 1'b0;
            narrow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q   <= bus.in_data;
                sign_q   <= bus.in_sign;
                narrow_q <= bus.in_narrow;
            end
        end
    end

`ifdef NARROW_OVF_CNT_EN
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (ovf_cnt_clr) begin
            ovf_cnt_d = '0;
        end else if (out_valid_c && bus.out_ready && out_ovf_c && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_narrow32t16_serializer.sv
// tb/tb_narrow32t16_serializer.sv - directed self-checking bench for narrow32t16_serializer
module tb_narrow32t16_serializer;
    logic clk;
    logic rst_n;
    int   vecs;
    int   errs;

    narrow32t16_serializer_if #(.IN_W(32), .OUT_W(16)) bus ();

`ifdef NARROW_OVF_CNT_EN
    logic       ovf_cnt_clr;
    logic [7:0] ovf_cnt;
`endif

    narrow32t16_serializer #(.IN_W(32), .OUT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave)
`ifdef NARROW_OVF_CNT_EN
        ,
        .ovf_cnt_clr (ovf_cnt_clr),
        .ovf_cnt     (ovf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic v, input logic [31:0] d, input logic s, input logic n);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_sign   = s;
        bus.in_narrow = n;
    endtask

    task automatic test_reset;
        @(negedge clk);
        #1;
        vecs++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0 || bus.out_last !== 1'b0 || bus.out_ovf !== 1'b0) begin
            errs++;
            $display("FAIL reset_outputs: got v=%b d=%h l=%b o=%b, want 0 0000 0 0",
                     bus.out_valid, bus.out_data, bus.out_last, bus.out_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vecs++;
        if (bus.in_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_in_ready: got %b, want 1", bus.in_ready);
        end
    endtask

    task automatic test_narrow_sign;
        @(negedge clk);
        bus.out_ready = 1'b1;
        drive(1'b1, 32'hFFFF_AAAA, 1'b1, 1'b1);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vecs++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hAAAA || bus.out_last !== 1'b1 || bus.out_ovf !== 1'b0) begin
            errs++;
            $display("FAIL narrow_sign_beat: got v=%b d=%h l=%b o=%b, want 1 aaaa 1 0",
                     bus.out_valid, bus.out_data, bus.out_last, bus.out_ovf);
        end
        @(negedge clk);
        #1;
        vecs++;
        if (bus.out_valid !== 1'b0) begin
            errs++;
            $display("FAIL narrow_sign_idle: got out_valid=%b, want 0", bus.out_valid);
        end
    endtask

    task automatic test_narrow_zero_ovf;
        @(negedge clk);
        drive(1'b1, 32'h0000_5555, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b1, 32'h0000_F0F0, 1'b1, 1'b1);
        #1;
        vecs++;
        if (bus.out_data !== 16'h5555 || bus.out_last !== 1'b1 || bus.out_ovf !== 1'b0) begin
            errs++;
            $display("FAIL narrow_zero_beat: got d=%h l=%b o=%b, want 5555 1 0",
                     bus.out_data, bus.out_last, bus.out_ovf);
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vecs++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hF0F0 || bus.out_ovf !== 1'b1) begin
            errs++;
            $display("FAIL narrow_ovf_beat: got v=%b d=%h o=%b, want 1 f0f0 1",
                     bus.out_valid, bus.out_data, bus.out_ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_full;
        @(negedge clk);
        drive(1'b1, 32'h1234_5678, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vecs++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h5678 || bus.out_last !== 1'b0 ||
            bus.out_ovf !== 1'b0 || bus.in_ready !== 1'b0) begin
            errs++;
            $display("FAIL full_lo_beat: got v=%b d=%h l=%b o=%b rdy=%b, want 1 5678 0 0 0",
                     bus.out_valid, bus.out_data, bus.out_last, bus.out_ovf, bus.in_ready);
        end
        @(negedge clk);
        #1;
        vecs++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h1234 || bus.out_last !== 1'b1 || bus.out_ovf !== 1'b0) begin
            errs++;
            $display("FAIL full_hi_beat: got v=%b d=%h l=%b o=%b, want 1 1234 1 0",
                     bus.out_valid, bus.out_data, bus.out_last, bus.out_ovf);
        end
        @(negedge clk);
        #1;
        vecs++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errs++;
            $display("FAIL full_idle: got v=%b rdy=%b, want 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] words [4];
        logic        signs [4];
        logic [15:0] exp_lo [4];
        words  = '{32'h0000_0001, 32'h0000_0002, 32'hFFFF_8003, 32'h0000_7FFF};
        signs  = '{1'b0, 1'b0, 1'b1, 1'b1};
        exp_lo = '{16'h0001, 16'h0002, 16'h8003, 16'h7FFF};
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i < 4) drive(1'b1, words[i], signs[i], 1'b1);
            else       drive(1'b0, 32'h0, 1'b0, 1'b0);
            #1;
            if (i < 4) begin
                vecs++;
                if (bus.in_ready !== 1'b1) begin
                    errs++;
                    $display("FAIL b2b_in_ready[%0d]: got %b, want 1", i, bus.in_ready);
                end
            end
            if (i > 0) begin
                vecs++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== exp_lo[i-1] || bus.out_ovf !== 1'b0) begin
                    errs++;
                    $display("FAIL b2b_beat[%0d]: got v=%b d=%h o=%b, want 1 %h 0",
                             i - 1, bus.out_valid, bus.out_data, bus.out_ovf, exp_lo[i-1]);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        drive(1'b1, 32'h1234_5678, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h0000_0042, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            vecs++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h1234 || bus.out_last !== 1'b1 || bus.in_ready !== 1'b0) begin
                errs++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h l=%b rdy=%b, want 1 1234 1 0",
                         i, bus.out_valid, bus.out_data, bus.out_last, bus.in_ready);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        vecs++;
        if (bus.in_ready !== 1'b1 || bus.out_data !== 16'h1234) begin
            errs++;
            $display("FAIL bp_release: got rdy=%b d=%h, want 1 1234", bus.in_ready, bus.out_data);
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        vecs++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0042 || bus.out_last !== 1'b1 || bus.out_ovf !== 1'b0) begin
            errs++;
            $display("FAIL bp_next_word: got v=%b d=%h l=%b o=%b, want 1 0042 1 0",
                     bus.out_valid, bus.out_data, bus.out_last, bus.out_ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset;
        @(negedge clk);
        drive(1'b1, 32'hAAAA_BBBB, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        vecs++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hAAAA) begin
            errs++;
            $display("FAIL mr_in_hi: got v=%b d=%h, want 1 aaaa", bus.out_valid, bus.out_data);
        end
        rst_n = 1'b0;
        #1;
        vecs++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0) begin
            errs++;
            $display("FAIL mr_async: got v=%b d=%h, want 0 0000", bus.out_valid, bus.out_data);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        vecs++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errs++;
            $display("FAIL mr_release: got rdy=%b v=%b, want 1 0", bus.in_ready, bus.out_valid);
        end
        @(negedge clk);
        #1;
        vecs++;
        if (bus.out_valid !== 1'b0) begin
            errs++;
            $display("FAIL mr_no_partial: got out_valid=%b, want 0", bus.out_valid);
        end
    endtask

`ifdef NARROW_OVF_CNT_EN
    task automatic test_ovf_cnt;
        @(negedge clk);
        ovf_cnt_clr = 1'b1;
        @(negedge clk);
        ovf_cnt_clr = 1'b0;
        #1;
        vecs++;
        if (ovf_cnt !== 8'd0) begin
            errs++;
            $display("FAIL cnt_clear: got %0d, want 0", ovf_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, 32'h0001_0000, 1'b0, 1'b1);
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        vecs++;
        if (ovf_cnt !== 8'd3) begin
            errs++;
            $display("FAIL cnt_three: got %0d, want 3", ovf_cnt);
        end
        drive(1'b1, 32'h0001_0000, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        ovf_cnt_clr = 1'b1;
        @(negedge clk);
        ovf_cnt_clr = 1'b0;
        #1;
        vecs++;
        if (ovf_cnt !== 8'd0) begin
            errs++;
            $display("FAIL cnt_clr_wins: got %0d, want 0", ovf_cnt);
        end
    endtask
`endif

    initial begin
        vecs = 0;
        errs = 0;
        rst_n = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
`ifdef NARROW_OVF_CNT_EN
        ovf_cnt_clr = 1'b0;
`endif
        test_reset();
        test_narrow_sign();
        test_narrow_zero_ovf();
        test_full();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
`ifdef NARROW_OVF_CNT_EN
        test_ovf_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
